vram_arbiter: RTL
=================

# vram_arbiter

Single-port video RAM and access arbiter sitting directly upstream of the chroni text/font generator. It owns the 2^ADDR_W x DATA_W video memory. Chroni's read port has absolute priority. CPU writes are buffered in a small FIFO and drained into idle (non-video) cycles. CPU reads are serviced one at a time in the first idle cycle after the write FIFO has drained.

## Interface
Parameters:
- ADDR_W, 11, address width; memory depth 2^ADDR_W.
- DATA_W, 8, data width.
- WFIFO_DEPTH, 4, write FIFO entries; power of two, ≥2.

Ports:
- vga_clk  in  1  single clock for the whole block.
- reset_n  in  1  reset; synchronous, active-low.
- vid_rd  in  1  video read slot request; top level drives it high during chroni's read window.
- vid_addr  in  ADDR_W  video read address (chroni addr_out).
- vid_data  out  DATA_W  video read data (chroni data_in); registered.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle pulse: request accepted this edge.
- cpu_rdata  out  DATA_W  CPU read data; valid when cpu_rvalid is high.
- cpu_rvalid  out  1  one-cycle pulse with read data.
- wfifo_level  out  $clog2(WFIFO_DEPTH)+1  current write-FIFO occupancy.

## Operation
- Each cycle carries exactly one RAM operation, chosen in this priority order:
  1. Video read, if vid_rd=1.
  2. Otherwise, FIFO head write, if the FIFO is not empty.
  3. Otherwise, pending CPU read.
  4. Otherwise, no operation.
- Write acceptance: cpu_req & cpu_we & FIFO not full & FSM in IDLE. On acceptance, {cpu_addr, cpu_wdata} is pushed and cpu_ack pulses. The write is retired later, in an idle slot.
- Read acceptance: cpu_req & ~cpu_we & FIFO empty & FSM in IDLE. On acceptance, the address is latched, cpu_ack pulses and the FSM moves to RD_WAIT. Requiring an empty FIFO guarantees read-after-write ordering.
- CPU FSM states:
  - IDLE: accepts new requests.
  - RD_WAIT: read latched, waiting for a slot with vid_rd=0. Issues the RAM read and moves to RD_DATA.
  - RD_DATA: captures RAM output into cpu_rdata, pulses cpu_rvalid, returns to IDLE.
- No request is accepted outside IDLE; cpu_ack stays low there.
- FIFO boundary conditions:
  - Push and pop on the same edge leave the level unchanged.
  - When full, write requests get no ack and the requester must hold cpu_req.
  - Pointers wrap modulo WFIFO_DEPTH.
- vid_data is updated only on the edge following a video read cycle. Otherwise it holds its value, so chroni may sample it several states later.
- Starvation: if vid_rd is held high permanently, CPU traffic stalls indefinitely. This is intended; chroni's window leaves ~25% of each line idle.
- Reset mid-operation:
  - FIFO flushed (level 0); pending read dropped, with no cpu_rvalid.
  - FSM returns to IDLE.
  - RAM contents are not cleared.

## Timing
- Reset values: vid_data=0, cpu_rdata=0, cpu_ack=0, cpu_rvalid=0, wfifo_level=0.
- Video latency: vid_addr is sampled at edge E with vid_rd=1, and vid_data holds the addressed byte from edge E+1.
- cpu_ack is registered and asserts on the edge that samples the accepting condition. The requester drops or changes cpu_req after seeing it.
- Write visibility: an entry pushed at edge E is written at the earliest edge ≥E+1 whose cycle has vid_rd=0. A video read in that same cycle sees the old data.
- CPU read, best case:
  - Accepted at edge E.
  - RAM read at E+1, if vid_rd=0 in that cycle.
  - cpu_rvalid and cpu_rdata at E+2.
  - Each cycle with vid_rd=1 adds one cycle.
- wfifo_level reflects the state after each edge.

## Structure
- Shared package chroni_pkg holds the VRAM_ADDR_W=11 and VRAM_DATA_W=8 constants and the CPU FSM state enum (IDLE, RD_WAIT, RD_DATA), reused by chroni.
- One sub-module, vram_spram: single-port RAM with synchronous write and registered synchronous read, inferred as block RAM.
- The write FIFO is inline (register array plus pointers and count); no separate module.

## Test plan
- Reset, then vid_rd=1 with vid_addr=0x010 over preloaded RAM[0x010]=0x41 -> vid_data=0x41 one edge later; all CPU outputs 0.
- vid_rd=0, write 0xA5 to 0x123, then read 0x123 -> cpu_ack on both, cpu_rvalid with cpu_rdata=0xA5 exactly 2 edges after the read ack.
- vid_rd=1 held for 20 cycles, 5 writes issued -> 4 acks, fifth stalls, wfifo_level=4. After vid_rd drops, level decrements by 1 per cycle, the fifth is acked, and the RAM holds all 5 values.
- Read requested while FIFO holds 2 entries with vid_rd=0 -> no ack for 2 cycles; the read then returns the newly written data.
- Read accepted, vid_rd toggling 1,1,0 -> cpu_rvalid 4 edges after ack; vid_data is correct for both video reads.
- reset_n low for one cycle with FIFO=3 and a read in RD_WAIT -> level 0, no cpu_rvalid, earlier retired RAM writes preserved.

Source files
------------

// File: rtl/chroni_pkg.sv
// Shared constants and CPU-port FSM encoding for the chroni video subsystem.
package chroni_pkg;

  localparam int unsigned VRAM_ADDR_W = 11;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DATA
  } cpu_state_t;

endpackage

// File: rtl/vram_spram.sv
// Single-port RAM: synchronous write, registered read-first output (block RAM style).
module vram_spram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM with video-priority arbitration, buffered CPU writes and one-at-a-time CPU reads.
module vram_arbiter
  import chroni_pkg::*;
#(
  parameter int unsigned ADDR_W      = VRAM_ADDR_W,
  parameter int unsigned DATA_W      = VRAM_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic                           vga_clk,
  input  logic                           reset_n,
  input  logic                           vid_rd,
  input  logic [ADDR_W-1:0]              vid_addr,
  output logic [DATA_W-1:0]              vid_data,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic                           cpu_ack,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_rvalid,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  cpu_state_t        state;
  cpu_state_t        state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              vid_pend;

  logic              fifo_empty;
  logic              fifo_full;
  logic              accept_wr;
  logic              accept_rd;
  logic              pop;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == LVL_W'(WFIFO_DEPTH));
  assign accept_wr   = (state == IDLE) && cpu_req && cpu_we && !fifo_full;
  assign accept_rd   = (state == IDLE) && cpu_req && !cpu_we && fifo_empty;
  assign pop         = !vid_rd && !fifo_empty;
  assign wfifo_level = level;

  // One RAM operation per cycle: video, then FIFO drain, then pending CPU read.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = fifo_data[rd_ptr];
    if (vid_rd) begin
      ram_addr = vid_addr;
    end else if (!fifo_empty) begin
      ram_we   = 1'b1;
      ram_addr = fifo_addr[rd_ptr];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_rd) state_next = RD_WAIT;
      RD_WAIT: if (!vid_rd && fifo_empty) state_next = RD_DATA;
      RD_DATA: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge vga_clk) begin
    if (accept_wr) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept_wr, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rd_addr    <= '0;
      vid_pend   <= 1'b0;
      vid_data   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      if (accept_rd) rd_addr <= cpu_addr;
      vid_pend   <= vid_rd;
      cpu_ack    <= accept_wr || accept_rd;
      cpu_rvalid <= (state == RD_DATA);
      if (vid_pend)          vid_data  <= ram_rdata;
      if (state == RD_DATA)  cpu_rdata <= ram_rdata;
    end
  end

  vram_spram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (vga_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
